// File: rtl/riscv_defines.sv
// Shared encodings for the DIFT tag path: propagation modes, class indices, TPR reset.
package riscv_defines;

   localparam int unsigned ALU_MODE_WIDTH  = 2;
   localparam int unsigned NUM_TAG_CLASSES = 16;
   localparam logic [31:0] TPR_RESET       = 32'h0;

   typedef enum logic [ALU_MODE_WIDTH-1:0] {
      ALU_MODE_OLD   = 2'b00,
      ALU_MODE_AND   = 2'b01,
      ALU_MODE_OR    = 2'b10,
      ALU_MODE_CLEAR = 2'b11
   } alu_mode_e;

   typedef enum logic [3:0] {
      TAG_CLS_ALU_RR = 4'd0,
      TAG_CLS_ALU_RI = 4'd1,
      TAG_CLS_SHIFT  = 4'd2,
      TAG_CLS_CMP    = 4'd3,
      TAG_CLS_MULDIV = 4'd4,
      TAG_CLS_LOAD   = 4'd5,
      TAG_CLS_STORE  = 4'd6,
      TAG_CLS_BRANCH = 4'd7,
      TAG_CLS_JUMP   = 4'd8,
      TAG_CLS_UPPER  = 4'd9,
      TAG_CLS_CSR    = 4'd10,
      TAG_CLS_RSV11  = 4'd11,
      TAG_CLS_RSV12  = 4'd12,
      TAG_CLS_RSV13  = 4'd13,
      TAG_CLS_RSV14  = 4'd14,
      TAG_CLS_RSV15  = 4'd15
   } tag_cls_e;

endpackage

// File: rtl/riscv_tpr_field_mux.sv
// Combinational lookup of the propagation mode for one instruction class from the TPR.
// Reserved classes are decoded like any other field.
module riscv_tpr_field_mux
   import riscv_defines::*;
#(
   parameter int unsigned MODE_WIDTH  = ALU_MODE_WIDTH,
   parameter int unsigned NUM_CLASSES = NUM_TAG_CLASSES
) (
   input  logic [NUM_CLASSES*MODE_WIDTH-1:0] tpr,
   input  logic [3:0]                        cls,
   output logic [MODE_WIDTH-1:0]             mode
);

   // Select field cls = tpr[2*cls+1:2*cls]
   always_comb begin
      mode = '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         if (32'(cls) == k) begin
            mode = tpr[k*MODE_WIDTH +: MODE_WIDTH];
         end
      end
   end

endmodule

// File: rtl/riscv_tag_prop_decoder.sv
// ID-stage tag propagation decoder: owns the TPR, maps instruction class to a
// propagation mode, masks immediate tags, and registers the result into the
// ID/EX tag pipeline entry feeding the tag ALU.
module riscv_tag_prop_decoder
   import riscv_defines::*;
#(
   parameter int unsigned ALU_MODE_WIDTH = riscv_defines::ALU_MODE_WIDTH,
   parameter int unsigned TAG_WIDTH      = 32,
   parameter int unsigned NUM_CLASSES    = NUM_TAG_CLASSES
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      tpr_we_i,
   input  logic [31:0]               tpr_wdata_i,
   output logic [31:0]               tpr_o,
   input  logic                      id_valid_i,
   input  logic [3:0]                id_class_i,
   input  logic                      id_use_imm_i,
   input  logic [TAG_WIDTH-1:0]      id_tag_a_i,
   input  logic [TAG_WIDTH-1:0]      id_tag_b_i,
   output logic                      id_ready_o,
   input  logic                      ex_ready_i,
   input  logic                      flush_i,
   output logic                      ex_valid_o,
   output logic [ALU_MODE_WIDTH-1:0] ex_operator_o,
   output logic [TAG_WIDTH-1:0]      ex_tag_a_o,
   output logic [TAG_WIDTH-1:0]      ex_tag_b_o
);

   localparam logic [ALU_MODE_WIDTH-1:0] MODE_OLD = ALU_MODE_WIDTH'(ALU_MODE_OLD);

   logic [31:0]               tpr_q;
   logic [ALU_MODE_WIDTH-1:0] id_mode;
   logic [TAG_WIDTH-1:0]      id_tag_b;
   logic                      ex_valid_q;
   logic [ALU_MODE_WIDTH-1:0] ex_operator_q;
   logic [TAG_WIDTH-1:0]      ex_tag_a_q;
   logic [TAG_WIDTH-1:0]      ex_tag_b_q;

   riscv_tpr_field_mux #(
      .MODE_WIDTH  (ALU_MODE_WIDTH),
      .NUM_CLASSES (NUM_CLASSES)
   ) u_field_mux (
      .tpr  (tpr_q),
      .cls  (id_class_i),
      .mode (id_mode)
   );

   assign id_tag_b   = id_use_imm_i ? '0 : id_tag_b_i;
   assign id_ready_o = ex_ready_i | ~ex_valid_q;

   // TPR: fully writable CSR, new value visible the cycle after the write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tpr_q <= TPR_RESET;
      end else if (tpr_we_i) begin
         tpr_q <= tpr_wdata_i;
      end
   end

   // ID/EX tag entry: flush beats load; invalid entries always carry OLD
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q    <= 1'b0;
         ex_operator_q <= MODE_OLD;
         ex_tag_a_q    <= '0;
         ex_tag_b_q    <= '0;
      end else if (flush_i) begin
         ex_valid_q    <= 1'b0;
         ex_operator_q <= MODE_OLD;
         ex_tag_a_q    <= '0;
         ex_tag_b_q    <= '0;
      end else if (id_ready_o) begin
         ex_valid_q    <= id_valid_i;
         ex_operator_q <= id_valid_i ? id_mode : MODE_OLD;
         ex_tag_a_q    <= id_tag_a_i;
         ex_tag_b_q    <= id_tag_b;
      end
   end

   assign tpr_o         = tpr_q;
   assign ex_valid_o    = ex_valid_q;
   assign ex_operator_o = ex_operator_q;
   assign ex_tag_a_o    = ex_tag_a_q;
   assign ex_tag_b_o    = ex_tag_b_q;

endmodule

// File: tb/tb_riscv_tag_prop_decoder.sv
// Self-checking bench for riscv_tag_prop_decoder: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_riscv_tag_prop_decoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tpr_we_i;
   logic [31:0] tpr_wdata_i;
   logic [31:0] tpr_o;
   logic        id_valid_i;
   logic [3:0]  id_class_i;
   logic        id_use_imm_i;
   logic [31:0] id_tag_a_i;
   logic [31:0] id_tag_b_i;
   logic        id_ready_o;
   logic        ex_ready_i;
   logic        flush_i;
   logic        ex_valid_o;
   logic [1:0]  ex_operator_o;
   logic [31:0] ex_tag_a_o;
   logic [31:0] ex_tag_b_o;

   always #5 clk = ~clk;

   riscv_tag_prop_decoder #(
      .ALU_MODE_WIDTH (2),
      .TAG_WIDTH      (32),
      .NUM_CLASSES    (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tpr_we_i      (tpr_we_i),
      .tpr_wdata_i   (tpr_wdata_i),
      .tpr_o         (tpr_o),
      .id_valid_i    (id_valid_i),
      .id_class_i    (id_class_i),
      .id_use_imm_i  (id_use_imm_i),
      .id_tag_a_i    (id_tag_a_i),
      .id_tag_b_i    (id_tag_b_i),
      .id_ready_o    (id_ready_o),
      .ex_ready_i    (ex_ready_i),
      .flush_i       (flush_i),
      .ex_valid_o    (ex_valid_o),
      .ex_operator_o (ex_operator_o),
      .ex_tag_a_o    (ex_tag_a_o),
      .ex_tag_b_o    (ex_tag_b_o)
   );

   // Reference model state
   logic [31:0] m_tpr;
   logic        m_valid;
   logic [1:0]  m_op;
   logic [31:0] m_a;
   logic [31:0] m_b;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] ref_mode(input logic [31:0] tpr, input int unsigned cls);
      return 2'((tpr >> (2 * cls)) % 4);
   endfunction

   task automatic model_reset();
      m_tpr   = 32'h0;
      m_valid = 1'b0;
      m_op    = 2'd0;
      m_a     = 32'h0;
      m_b     = 32'h0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".valid"}, 32'(ex_valid_o), 32'(m_valid));
      check({tag, ".op"}, 32'(ex_operator_o), 32'(m_op));
      check({tag, ".tpr"}, tpr_o, m_tpr);
      if (m_valid) begin
         check({tag, ".tag_a"}, ex_tag_a_o, m_a);
         check({tag, ".tag_b"}, ex_tag_b_o, m_b);
      end
   endtask

   // Apply current inputs for one clock, advance the model, compare.
   task automatic step(input string tag);
      logic        rdy;
      logic        nv;
      logic [1:0]  nop;
      logic [31:0] na;
      logic [31:0] nb;
      #1;
      rdy = ex_ready_i | ~m_valid;
      check({tag, ".id_ready"}, 32'(id_ready_o), 32'(rdy));
      nv = m_valid; nop = m_op; na = m_a; nb = m_b;
      if (flush_i) begin
         nv = 1'b0; nop = 2'd0; na = '0; nb = '0;
      end else if (rdy) begin
         nv  = id_valid_i;
         nop = id_valid_i ? ref_mode(m_tpr, 32'(id_class_i)) : 2'd0;
         na  = id_tag_a_i;
         nb  = id_use_imm_i ? 32'h0 : id_tag_b_i;
      end
      @(posedge clk);
      #1;
      if (tpr_we_i) m_tpr = tpr_wdata_i;
      m_valid = nv; m_op = nop; m_a = na; m_b = nb;
      check_outputs(tag);
   endtask

   task automatic idle_inputs();
      tpr_we_i = 0; tpr_wdata_i = '0; id_valid_i = 0; id_class_i = '0;
      id_use_imm_i = 0; id_tag_a_i = '0; id_tag_b_i = '0; ex_ready_i = 1; flush_i = 0;
   endtask

   task automatic issue(input logic [3:0] cls, input logic imm, input logic [31:0] a, input logic [31:0] b);
      id_valid_i = 1; id_class_i = cls; id_use_imm_i = imm; id_tag_a_i = a; id_tag_b_i = b;
   endtask

   initial begin
      logic [31:0] prog;
      idle_inputs();
      model_reset();
      rst_n = 0;
      #12;
      check("reset.valid", 32'(ex_valid_o), 32'h0);
      check("reset.op", 32'(ex_operator_o), 32'h0);
      check("reset.tag_a", ex_tag_a_o, 32'h0);
      check("reset.tag_b", ex_tag_b_o, 32'h0);
      check("reset.tpr", tpr_o, 32'h0);
      @(negedge clk);
      rst_n = 1;

      // 1. basic decode with TPR at reset value
      issue(4'd0, 0, 32'h1, 32'h2);
      step("basic");
      check("basic.op_old", 32'(ex_operator_o), 32'h0);
      check("basic.b", ex_tag_b_o, 32'h2);

      // 2. TPR write; decode in write cycle uses old TPR
      tpr_we_i = 1; tpr_wdata_i = 32'h0000_0006;
      issue(4'd0, 0, 32'h10, 32'h20);
      step("wr_cycle");
      check("wr_cycle.op_old", 32'(ex_operator_o), 32'h0);
      tpr_we_i = 0;
      step("after_wr");
      check("after_wr.op_or", 32'(ex_operator_o), 32'h2);
      issue(4'd1, 1, 32'h33, 32'hFF);
      step("imm");
      check("imm.op_and", 32'(ex_operator_o), 32'h1);
      check("imm.b_zero", ex_tag_b_o, 32'h0);

      // 3. stall holding an OR entry while TPR is rewritten
      issue(4'd0, 0, 32'hA, 32'hB);
      step("pre_stall");
      ex_ready_i = 0;
      issue(4'd5, 0, 32'h55, 32'h66);
      tpr_we_i = 1; tpr_wdata_i = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         step("stall");
         tpr_we_i = 0;
         check("stall.id_ready0", 32'(id_ready_o), 32'h0);
         check("stall.op_or", 32'(ex_operator_o), 32'h2);
      end
      ex_ready_i = 1;
      step("unstall");
      step("post_stall");
      check("post_stall.op_clear", 32'(ex_operator_o), 32'h3);

      // 4. flush beats a simultaneous load
      flush_i = 1;
      issue(4'd2, 0, 32'h77, 32'h88);
      step("flush");
      flush_i = 0;
      check("flush.valid0", 32'(ex_valid_o), 32'h0);
      check("flush.op_old", 32'(ex_operator_o), 32'h0);
      check("flush.tag_a0", ex_tag_a_o, 32'h0);
      check("flush.tag_b0", ex_tag_b_o, 32'h0);

      // 5. program class k with k mod 4 and sweep all classes
      prog = '0;
      for (int unsigned k = 0; k < 16; k++) prog = prog | ((k % 4) << (2 * k));
      id_valid_i = 0; tpr_we_i = 1; tpr_wdata_i = prog;
      step("prog");
      tpr_we_i = 0;
      for (int unsigned k = 0; k < 16; k++) begin
         issue(4'(k), 0, k, ~k);
         step("sweep");
         check("sweep.op_kmod4", 32'(ex_operator_o), k % 4);
      end

      // 6. asynchronous reset in the middle of a stall
      issue(4'd3, 0, 32'hC3, 32'hD3);
      step("pre_rst");
      ex_ready_i = 0;
      step("rst_stall");
      #3;
      rst_n = 0;
      #1;
      model_reset();
      check("async_rst.valid", 32'(ex_valid_o), 32'h0);
      check("async_rst.op", 32'(ex_operator_o), 32'h0);
      check("async_rst.tag_a", ex_tag_a_o, 32'h0);
      check("async_rst.tag_b", ex_tag_b_o, 32'h0);
      check("async_rst.tpr", tpr_o, 32'h0);
      check("async_rst.id_ready", 32'(id_ready_o), 32'h1);
      @(negedge clk);
      rst_n = 1;
      ex_ready_i = 1;
      issue(4'd3, 0, 32'h1234, 32'h5678);
      step("first_after_rst");
      check("first_after_rst.op_old", 32'(ex_operator_o), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         tpr_we_i     = ($urandom_range(0, 7) == 0);
         tpr_wdata_i  = $urandom;
         id_valid_i   = ($urandom_range(0, 3) != 0);
         id_class_i   = 4'($urandom_range(0, 15));
         id_use_imm_i = $urandom_range(0, 1) == 1;
         id_tag_a_i   = $urandom;
         id_tag_b_i   = $urandom;
         ex_ready_i   = ($urandom_range(0, 2) != 0);
         flush_i      = ($urandom_range(0, 15) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_tag_prop_decoder.md
# riscv_tag_prop_decoder

- Sits in the RI5CY DIFT tag path, directly upstream of the tag ALU (`riscv_alu_tag`).
- Owns the Tag Propagation Register (TPR), written through the CSR port.
- In ID, it maps the current instruction's class to a 2-bit propagation mode through the TPR, and selects the source-operand tags (immediate tag forced clean).
- It registers mode and tags into an ID/EX tag pipeline register with stall and flush. The register drives `operator_i`, `operand_a_i` and `operand_b_i` of the tag ALU.

## Interface
- ALU_MODE_WIDTH, 2, width of propagation mode (from riscv_defines)
- TAG_WIDTH, 32, width of one operand tag
- NUM_CLASSES, 16, instruction classes held in the TPR (NUM_CLASSES*ALU_MODE_WIDTH = 32)

Ports:
- clk  input  1  core clock; the only clock
- rst_n  input  1  reset, asynchronous, active-low
- tpr_we_i  input  1  CSR write strobe for TPR
- tpr_wdata_i  input  32  CSR write data
- tpr_o  output  32  current TPR value (CSR read path)
- id_valid_i  input  1  ID holds a valid instruction
- id_class_i  input  4  instruction class index
- id_use_imm_i  input  1  operand B is an immediate
- id_tag_a_i  input  TAG_WIDTH  tag of rs1 from tag RF
- id_tag_b_i  input  TAG_WIDTH  tag of rs2 from tag RF
- id_ready_o  output  1  stage can accept the ID instruction
- ex_ready_i  input  1  EX consumes the registered entry this cycle
- flush_i  input  1  kill the ID/EX tag entry
- ex_valid_o  output  1  registered entry valid
- ex_operator_o  output  ALU_MODE_WIDTH  mode to tag ALU
- ex_tag_a_o  output  TAG_WIDTH  operand A tag to tag ALU
- ex_tag_b_o  output  TAG_WIDTH  operand B tag to tag ALU

## Operation
**Mode encoding**
- ALU_MODE_OLD=2'b00, ALU_MODE_AND=2'b01, ALU_MODE_OR=2'b10, ALU_MODE_CLEAR=2'b11.

**TPR fields and classes**
- Field k = TPR[2k+1:2k] gives the mode for class k.
- Classes: 0 reg-reg ALU, 1 reg-imm ALU, 2 shift, 3 compare, 4 mul/div, 5 load, 6 store, 7 branch, 8 jal/jalr, 9 lui/auipc, 10 CSR, 11-15 reserved.
- Reserved classes are decoded from their fields like any other class. There is no special case.

**Decode**
- mode = TPR field[id_class_i].
- tag_a = id_tag_a_i.
- tag_b = id_use_imm_i ? 0 : id_tag_b_i.

**TPR update**
- On tpr_we_i, the TPR loads tpr_wdata_i in full. Every bit is writable.

**Pipeline register**
- id_ready_o = ex_ready_i | ~ex_valid_o.
- Load happens when id_ready_o: ex_valid_o ← id_valid_i, and mode/tags ← decoded values.
- If id_ready_o=1 and id_valid_i=0, ex_valid_o drops to 0 and ex_operator_o ← OLD.
- Otherwise the register holds.

**Invalid entries**
- When ex_valid_o=0, ex_operator_o is always OLD, so the tag RF write enable is low.

**Flush**
- flush_i has highest priority: ex_valid_o←0, ex_operator_o←OLD, tags←0.
- A flush in the same cycle as a load discards the load.

## Timing
- Reset values: TPR=0 (all classes OLD, propagation off), ex_valid_o=0, ex_operator_o=OLD, ex_tag_a_o=0, ex_tag_b_o=0.
- tpr_o=0 during reset.
- Decode-to-EX latency is 1 cycle.
- id_ready_o is combinational from ex_ready_i and ex_valid_o.
- TPR write takes effect the cycle after tpr_we_i. An instruction decoded in the write cycle uses the old TPR. There is no bypass.
- tpr_o reflects the new value one cycle after the write.
- If a stall (ex_ready_i=0, ex_valid_o=1) coincides with a TPR write, the held entry keeps its already-decoded mode.
- Reset asserted mid-stall clears the entry and the TPR immediately (asynchronous). The first valid load after reset uses OLD unless the TPR is written first.
- There are no other internal states: the block is a 1-entry valid/hold register plus the TPR.

## Structure
**riscv_defines package**
- ALU_MODE_* encodings, ALU_MODE_WIDTH.
- TAG_CLS_* class indices (4-bit), NUM_TAG_CLASSES.
- TPR_RESET (32'h0).

**Sub-module**
- One sub-module: riscv_tpr_field_mux, a combinational lookup of TPR[class] → mode, reused by the tag check logic.
- The TPR flop and the pipeline register stay in riscv_tag_prop_decoder.

## Test plan
1. **Reset, then basic decode.** Reset, then issue class 0 with tags A=32'h1, B=32'h2. Required: ex_operator_o=OLD, ex_valid_o=1 next cycle, ex_tag_a_o=1, ex_tag_b_o=2.
2. **TPR write and immediate masking.** Write TPR=32'h0000_0006 (class0=OR, class1=AND).
   - Class 0: issuing it in the write cycle yields OLD; issuing it one cycle later yields OR.
   - Class 1 with id_use_imm_i=1 and B=32'hFF: yields AND with ex_tag_b_o=0.
3. **Stall hold.** Hold ex_ready_i=0 for 3 cycles with a valid entry (mode OR) while ID presents class 5 and the TPR is rewritten to 32'hFFFF_FFFF. Required:
   - id_ready_o=0 and the entry is unchanged (OR) throughout.
   - After ex_ready_i=1, the next load yields CLEAR.
4. **Flush priority.** Assert flush_i together with a valid load. Required: next cycle ex_valid_o=0, ex_operator_o=OLD, tags 0.
5. **Reserved-class decode.** Program each class k with mode k mod 4 and sweep id_class_i 0-15. Required: ex_operator_o = k mod 4, including reserved classes 11-15.
6. **Asynchronous reset mid-stall.** Assert rst_n=0 asynchronously between clock edges during a stall. Required: outputs and tpr_o go to their reset values immediately, with no clock edge needed.
